// File: rtl/if_fetch_ctrl_if.sv
// Handshake/bus bundle between the IF-stage fetch controller and the rest of the core.
// The fetch controller connects through the master modport; the core/ROM side uses slave.
interface if_fetch_ctrl_if;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        stall;
   logic        jmp_en;
   logic [25:0] jmp_index;
   logic        jr_en;
   logic [31:0] jr_target;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] br_pc;
   logic        exc_en;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        flush_id_ex;
   logic        halted;
   logic [31:0] fetch_cnt;

   modport master (
      output rom_addr, if_id_instr, if_id_pc4, if_id_valid, flush_id_ex, halted, fetch_cnt,
      input  rom_data, stall, jmp_en, jmp_index, jr_en, jr_target,
             br_taken, br_target, br_pc, exc_en
   );

   modport slave (
      input  rom_addr, if_id_instr, if_id_pc4, if_id_valid, flush_id_ex, halted, fetch_cnt,
      output rom_data, stall, jmp_en, jmp_index, jr_en, jr_target,
             br_taken, br_target, br_pc, exc_en
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID, arbitrates next-PC and detects halt.
// Define FETCH_STATS_EN to build the fetch_cnt counter; otherwise fetch_cnt reads as zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | first cycle after reset, pc held, IF/ID bubble
// ST_RUN  | normal fetch with redirect/stall arbitration
// ST_HALT | terminal self-loop seen, pc frozen until exception
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EXC_PC   = 32'h8000_0004,
   parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           reset,
   if_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;

   logic [31:0] pc_plus4;
   logic [31:0] jmp_pc;
   logic        redirect;
   logic        self_loop;

   assign pc_plus4  = pc_q + 32'd4;
   assign jmp_pc    = {pc4_q[31:28], bus.jmp_index, 2'b00};
   assign redirect  = bus.exc_en | bus.br_taken | bus.jr_en | bus.jmp_en;
   assign self_loop = bus.br_taken && (bus.br_target == bus.br_pc) && !bus.exc_en;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            instr_d = BUBBLE;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
         end
         ST_RUN: begin
            if (redirect) begin
               instr_d = BUBBLE;
               pc4_d   = 32'h0;
               valid_d = 1'b0;
            end else if (!bus.stall) begin
               instr_d = bus.rom_data;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
            end
            // jr beats j when both decode in the same cycle
            if (bus.exc_en) begin
               pc_d = EXC_PC;
            end else if (bus.br_taken) begin
               pc_d = self_loop ? bus.br_pc : bus.br_target;
               if (self_loop) state_d = ST_HALT;
            end else if (bus.jr_en) begin
               pc_d = bus.jr_target;
            end else if (bus.jmp_en) begin
               pc_d = jmp_pc;
            end else if (!bus.stall) begin
               pc_d = pc_plus4;
            end
         end
         ST_HALT: begin
            instr_d = BUBBLE;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            if (bus.exc_en) begin
               pc_d    = EXC_PC;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
      pc_d[1:0] = 2'b00;
      halted_d  = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         instr_q  <= BUBBLE;
         pc4_q    <= 32'h0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc4_q    <= pc4_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic        cnt_inc;

   // counts only real loads; HALT never loads so the count freezes there
   assign cnt_inc = (state_q == ST_RUN) && !redirect && !bus.stall;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (cnt_inc) fetch_cnt_d = fetch_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fetch_cnt_q <= 32'h0;
      else       fetch_cnt_q <= fetch_cnt_d;
   end

   assign bus.fetch_cnt = fetch_cnt_q;
`else
   assign bus.fetch_cnt = 32'h0;
`endif

   assign bus.rom_addr    = pc_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc4   = pc4_q;
   assign bus.if_id_valid = valid_q;
   assign bus.halted      = halted_q;
   assign bus.flush_id_ex = (state_q == ST_RUN) && (bus.br_taken || bus.exc_en);

endmodule
